// File: rtl/uart_apb_seq.sv
// APB master that initialises a uart_apb peripheral, then polls its status and moves RX/TX bytes.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module uart_apb_seq #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] ADDR_CTRL    = 12'h000,
  parameter logic [ADDR_W-1:0] ADDR_DIV     = 12'h004,
  parameter logic [ADDR_W-1:0] ADDR_STAT    = 12'h008,
  parameter logic [ADDR_W-1:0] ADDR_RXD     = 12'h00C,
  parameter logic [ADDR_W-1:0] ADDR_TXD     = 12'h010,
  parameter logic [31:0]       CTRL_VAL     = 32'h0000_0003,
  parameter int                STAT_RXV_BIT = 0,
  parameter int                STAT_TXB_BIT = 1,
  parameter int                TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cfg_div,
  input  logic              cfg_start,
  output logic              init_done,
  output logic              err,
  input  logic              tx_valid,
  input  logic [7:0]        tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              m_psel,
  output logic              m_penable,
  output logic [2:0]        m_pprot,
  output logic [ADDR_W-1:0] m_paddr,
  output logic              m_pwrite,
  output logic [31:0]       m_pwdata,
  output logic [3:0]        m_pstrb,
  input  logic              m_pready,
  input  logic              m_pslverr,
  input  logic [31:0]       m_prdata
);

  typedef enum logic [2:0] {CFG_DIV, CFG_CTRL, IDLE, POLL, RD_RX, WR_TX} state_t;
  typedef enum logic [1:0] {PH_NONE, PH_SETUP, PH_ACCESS} phase_t;

  state_t state, tgt;
  phase_t phase;
  logic   last_tx;
  logic   launch, drop, done, abort, rx_elig, tx_elig;
  logic   prdata_unused;

  function automatic logic [ADDR_W-1:0] addr_of(input state_t s);
    case (s)
      CFG_DIV:  return ADDR_DIV;
      CFG_CTRL: return ADDR_CTRL;
      POLL:     return ADDR_STAT;
      RD_RX:    return ADDR_RXD;
      WR_TX:    return ADDR_TXD;
      default:  return '0;
    endcase
  endfunction

  function automatic logic is_write(input state_t s);
    return (s == CFG_DIV) || (s == CFG_CTRL) || (s == WR_TX);
  endfunction

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  assign abort = (phase == PH_ACCESS) && !m_pready && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  assign done          = (phase == PH_ACCESS) && m_pready;
  assign rx_elig       = m_prdata[STAT_RXV_BIT];
  assign tx_elig       = tx_valid && !m_prdata[STAT_TXB_BIT];
  assign tx_ready      = !reset && done && (state == WR_TX) && !m_pslverr;
  assign m_pprot       = 3'b000;
  assign prdata_unused = ^m_prdata;

  // Next access selection: launch starts a SETUP phase this edge, drop returns the bus to IDLE.
  always_comb begin
    tgt    = state;
    launch = 1'b0;
    drop   = 1'b0;
    case (phase)
      PH_NONE: begin
        launch = 1'b1;
        if (state == IDLE) tgt = cfg_start ? CFG_DIV : POLL;
      end
      PH_ACCESS: begin
        if (done || abort) begin
          case (state)
            CFG_DIV: begin
              launch = 1'b1;
              tgt    = CFG_CTRL;
            end
            POLL: begin
              if (done && !m_pslverr && (rx_elig || tx_elig)) begin
                launch = 1'b1;
                tgt    = (rx_elig && (!tx_elig || last_tx)) ? RD_RX : WR_TX;
              end else begin
                drop = 1'b1;
              end
            end
            default: drop = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CFG_DIV;
      phase     <= PH_NONE;
      last_tx   <= 1'b1;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_paddr   <= '0;
      m_pwrite  <= 1'b0;
      m_pwdata  <= '0;
      m_pstrb   <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (launch) begin
        state     <= tgt;
        phase     <= PH_SETUP;
        m_psel    <= 1'b1;
        m_penable <= 1'b0;
        m_paddr   <= addr_of(tgt);
        m_pwrite  <= is_write(tgt);
        m_pstrb   <= is_write(tgt) ? 4'hF : 4'h0;
        case (tgt)
          CFG_DIV:  m_pwdata <= {16'b0, cfg_div};
          CFG_CTRL: m_pwdata <= CTRL_VAL;
          WR_TX:    m_pwdata <= {24'b0, tx_data};
          default:  m_pwdata <= '0;
        endcase
        if (tgt == RD_RX) last_tx <= 1'b0;
        if (tgt == WR_TX) last_tx <= 1'b1;
      end else if (phase == PH_SETUP) begin
        phase     <= PH_ACCESS;
        m_penable <= 1'b1;
      end else if (drop) begin
        state     <= IDLE;
        phase     <= PH_NONE;
        m_psel    <= 1'b0;
        m_penable <= 1'b0;
      end

      if (state == IDLE && phase == PH_NONE && cfg_start) init_done <= 1'b0;
      if ((done || abort) && state == CFG_CTRL) init_done <= 1'b1;
      if ((done && m_pslverr) || abort) err <= 1'b1;
      // A failed RX read is not delivered; the byte stays pending in the UART.
      if (done && !m_pslverr && state == RD_RX) begin
        rx_valid <= 1'b1;
        rx_data  <= m_prdata[7:0];
      end
`ifdef APB_TIMEOUT_EN
      if (phase == PH_ACCESS && !m_pready) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                 tmo_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_apb_seq.sv
// Scoreboard bench for uart_apb_seq: a slave model answers the APB bus, a monitor pops expected events.
module tb_uart_apb_seq;

  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_DIV  = 12'h004;
  localparam logic [11:0] A_STAT = 12'h008;
  localparam logic [11:0] A_RXD  = 12'h00C;
  localparam logic [11:0] A_TXD  = 12'h010;
  localparam int K_APB = 0, K_RX = 1, K_TX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_div;
  logic        cfg_start;
  logic        init_done, err;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        m_psel, m_penable, m_pwrite;
  logic [2:0]  m_pprot;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic        m_pready, m_pslverr;
  logic [31:0] m_prdata;

  always #5 clk = ~clk;

  uart_apb_seq dut (
    .clk(clk), .reset(reset), .cfg_div(cfg_div), .cfg_start(cfg_start),
    .init_done(init_done), .err(err), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .m_psel(m_psel), .m_penable(m_penable), .m_pprot(m_pprot), .m_paddr(m_paddr),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic        wr;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0, n_fail = 0;

  // Slave model controls: written only by the stimulus process
  logic [31:0] stat_val = 32'h0, rxd_val = 32'h0;
  int          wait_total = 0, err_total = 0;
  logic        hold_low = 1'b0;
  // Slave model bookkeeping: written only by the slave process
  int          wait_used = 0, err_used = 0;
  // Monitor counters: written only by the monitor process
  int          poll_cnt = 0, wait_cycles = 0, rx_hi = 0, tx_hi = 0;
  logic [11:0] snap_addr;
  logic        snap_wr;
  logic [31:0] snap_wd;
  logic [3:0]  snap_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [11:0] a, input logic w, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.wr = w; e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input string name, input int k, input logic [11:0] a, input logic w,
                        input logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected event kind=%0d addr=%h data=%h, expected no event", name, k, a, d);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, 32'(k), 32'(e.kind));
      check({name, "_addr_wr"}, {19'b0, a, w}, {19'b0, e.addr, e.wr});
      check({name, "_data"}, d, e.data);
    end
  endtask

  // APB slave: responses change on the falling edge so the DUT sees them settled at posedge
  initial begin
    m_pready = 1'b1; m_pslverr = 1'b0; m_prdata = 32'h0;
    forever begin
      @(negedge clk);
      m_prdata  = (m_paddr == A_STAT) ? stat_val : (m_paddr == A_RXD) ? rxd_val : 32'h0;
      m_pready  = 1'b1;
      m_pslverr = 1'b0;
      if (m_psel && m_penable) begin
        if (hold_low) m_pready = 1'b0;
        else if (m_paddr == A_STAT && wait_used < wait_total) begin
          m_pready = 1'b0;
          wait_used++;
        end else if (m_paddr == A_TXD && m_pwrite && err_used < err_total) begin
          m_pslverr = 1'b1;
          err_used++;
        end
      end
    end
  end

  // Monitor: STAT polls are counted; every other completed access and every pulse goes through the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (m_psel && !m_penable) begin
          snap_addr = m_paddr; snap_wr = m_pwrite; snap_wd = m_pwdata; snap_strb = m_pstrb;
        end
        if (m_psel && m_penable) begin
          check("acc_addr_stable", {20'b0, m_paddr}, {20'b0, snap_addr});
          check("acc_wr_stable", {31'b0, m_pwrite}, {31'b0, snap_wr});
          check("acc_wdata_stable", m_pwdata, snap_wd);
          check("acc_strb_stable", {28'b0, m_pstrb}, {28'b0, snap_strb});
          if (!m_pready) wait_cycles++;
          else begin
            check("pstrb", {28'b0, m_pstrb}, m_pwrite ? 32'hF : 32'h0);
            check("pprot", {29'b0, m_pprot}, 32'h0);
            if (m_paddr == A_STAT && !m_pwrite) poll_cnt++;
            else sb_pop("apb", K_APB, m_paddr, m_pwrite, m_pwrite ? m_pwdata : 32'h0);
          end
        end
        if (tx_ready) begin
          tx_hi++;
          sb_pop("tx_ready", K_TX, 12'h0, 1'b0, m_pwdata);
        end
        if (rx_valid) begin
          rx_hi++;
          sb_pop("rx_valid", K_RX, 12'h0, 1'b0, {24'b0, rx_data});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_sb(input string name, input int max);
    int i = 0;
    while (sb.size() != 0 && i < max) begin step(); i++; end
    check(name, 32'(sb.size()), 32'h0);
  endtask

  task automatic wait_polls(input string name, input int n, input int max);
    int p0 = poll_cnt;
    int i = 0;
    while (poll_cnt < p0 + n && i < max) begin step(); i++; end
    check(name, 32'(poll_cnt - p0), 32'(n));
  endtask

  task automatic push_init(input logic [15:0] div);
    push(K_APB, A_DIV, 1'b1, {16'b0, div});
    push(K_APB, A_CTRL, 1'b1, 32'h3);
  endtask

  initial begin
    int c0, i, n;
    reset = 1'b1; cfg_start = 1'b0; cfg_div = 16'h0036; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) step();

    check("rst_psel", {31'b0, m_psel}, 32'h0);
    check("rst_penable", {31'b0, m_penable}, 32'h0);
    check("rst_paddr", {20'b0, m_paddr}, 32'h0);
    check("rst_pwrite", {31'b0, m_pwrite}, 32'h0);
    check("rst_pwdata", m_pwdata, 32'h0);
    check("rst_pstrb", {28'b0, m_pstrb}, 32'h0);
    check("rst_init_done", {31'b0, init_done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'h0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
    check("rst_rx_data", {24'b0, rx_data}, 32'h0);

    // Init: DIV then CTRL, init_done after the fifth edge
    push_init(16'h0036);
    reset = 1'b0;
    @(posedge clk); #1;
    check("init_setup", {18'b0, m_psel, m_penable, m_paddr}, {18'b0, 1'b1, 1'b0, A_DIV});
    repeat (3) @(posedge clk);
    #1;
    check("init_done_cyc4", {31'b0, init_done}, 32'h0);
    @(posedge clk); #1;
    check("init_done_cyc5", {31'b0, init_done}, 32'h1);
    check("init_bus_idle", {31'b0, m_psel}, 32'h0);
    wait_sb("init_sb", 20);

    // RX delivery, then no further pulse once STAT is clear
    c0 = rx_hi;
    rxd_val = 32'h0000_00A5;
    stat_val = 32'h1;
    push(K_APB, A_RXD, 1'b0, 32'h0);
    push(K_RX, 12'h0, 1'b0, 32'hA5);
    wait_sb("rx_sb", 30);
    stat_val = 32'h0;
    repeat (15) step();
    check("rx_single_pulse", 32'(rx_hi - c0), 32'h1);

    // TX blocked while busy, then exactly one write
    c0 = tx_hi;
    stat_val = 32'h2;
    tx_data = 8'h5A;
    step();
    tx_valid = 1'b1;
    wait_polls("tx_busy_polls", 3, 40);
    check("tx_blocked", 32'(tx_hi - c0), 32'h0);
    push(K_APB, A_TXD, 1'b1, 32'h5A);
    push(K_TX, 12'h0, 1'b0, 32'h5A);
    stat_val = 32'h0;
    wait_sb("tx_sb", 30);
    tx_valid = 1'b0;
    repeat (15) step();
    check("tx_single_pulse", 32'(tx_hi - c0), 32'h1);

    // Four wait states on a POLL
    c0 = wait_cycles;
    wait_total = wait_used + 4;
    wait_polls("wait_polls", 2, 60);
    check("wait_cycles", 32'(wait_cycles - c0), 32'h4);

    // pslverr on a TXD write: err set, no tx_ready, retried
    check("err_before", {31'b0, err}, 32'h0);
    c0 = tx_hi;
    err_total = err_used + 1;
    tx_data = 8'hC3;
    push(K_APB, A_TXD, 1'b1, 32'hC3);
    push(K_APB, A_TXD, 1'b1, 32'hC3);
    push(K_TX, 12'h0, 1'b0, 32'hC3);
    tx_valid = 1'b1;
    wait_sb("slverr_sb", 40);
    tx_valid = 1'b0;
    check("err_sticky", {31'b0, err}, 32'h1);
    check("slverr_one_ready", 32'(tx_hi - c0), 32'h1);

    // cfg_start in IDLE re-runs init with the new divisor
    cfg_div = 16'h1234;
    i = 0;
    while (m_psel && i < 10) begin step(); i++; end
    check("reached_idle", {31'b0, m_psel}, 32'h0);
    push_init(16'h1234);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check("reinit_clear", {31'b0, init_done}, 32'h0);
    wait_sb("reinit_sb", 30);
    step();
    check("reinit_done", {31'b0, init_done}, 32'h1);

    // cfg_start outside IDLE is ignored
    i = 0;
    while (!(m_psel && !m_penable) && i < 10) begin step(); i++; end
    check("reached_setup", {30'b0, m_psel, m_penable}, 32'h2);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (12) step();
    check("start_ignored", {31'b0, init_done}, 32'h1);

    // Round-robin after reset: RX first, then alternate
    reset = 1'b1;
    stat_val = 32'h1;
    rxd_val = 32'h0000_0011;
    tx_data = 8'h22;
    tx_valid = 1'b1;
    step();
    step();
    check("rr_err_cleared", {31'b0, err}, 32'h0);
    push_init(16'h1234);
    for (int k = 0; k < 2; k++) begin
      push(K_APB, A_RXD, 1'b0, 32'h0);
      push(K_RX, 12'h0, 1'b0, 32'h11);
      push(K_APB, A_TXD, 1'b1, 32'h22);
      push(K_TX, 12'h0, 1'b0, 32'h22);
    end
    reset = 1'b0;
    wait_sb("rr_sb", 80);
    stat_val = 32'h0;
    tx_valid = 1'b0;
    repeat (10) step();

    // Reset in the middle of a stalled ACCESS
    wait_total = wait_used + 10;
    i = 0;
    while (!(m_psel && m_penable && !m_pready) && i < 20) begin step(); i++; end
    check("reached_stall", {30'b0, m_psel, m_penable}, 32'h3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_psel", {31'b0, m_psel}, 32'h0);
    check("midrst_penable", {31'b0, m_penable}, 32'h0);
    check("midrst_init_done", {31'b0, init_done}, 32'h0);
    wait_total = wait_used;
    step();
    push_init(16'h1234);
    reset = 1'b0;
    wait_sb("midrst_sb", 30);

`ifdef APB_TIMEOUT_EN
    // ACCESS never acknowledged: aborted after 64 cycles
    hold_low = 1'b1;
    i = 0;
    while (!(m_psel && !m_penable) && i < 10) begin step(); i++; end
    step();
    n = 0;
    while (m_psel && m_penable && n < 200) begin n++; step(); end
    check("timeout_cycles", 32'(n), 32'd64);
    check("timeout_err", {31'b0, err}, 32'h1);
    hold_low = 1'b0;
    repeat (10) step();
`else
    n = 0;
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
